// File: rtl/multi_pulse_timestamper_if.sv
// AXI-Stream style channel carrying {channel id, stamp} beats from the
// timestamper to the DMA path.
interface multi_pulse_timestamper_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/multi_pulse_timestamper.sv
// Multi-channel pulse timestamper: synchronise, edge-detect and stamp each line,
// merge stamps round-robin into a FWFT FIFO that drives an AXI-Stream master.
module multi_pulse_timestamper #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned ID_W       = 3,
  parameter int unsigned TS_W       = 29,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DEADTIME   = 0
) (
  input  logic                          sample_clk,
  input  logic                          resetn,
  input  logic [NUM_CH-1:0]             pulse_i,
  input  logic [NUM_CH-1:0]             ch_enable,
  multi_pulse_timestamper_if.master     m_axis,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned DW  = ID_W + TS_W;
  localparam int unsigned PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DTW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

  typedef enum logic [1:0] {ST_WARM0, ST_WARM1, ST_RUN} warm_state_t;

  warm_state_t       r_state, w_state_nxt;
  logic              w_armed;

  logic [TS_W-1:0]   r_ts_ctr, r_ts_d1;
  logic [NUM_CH-1:0] r_sync1, r_sync2, r_prev;
  logic [NUM_CH-1:0] w_rise, w_dead, w_accept, w_drop;

  logic [NUM_CH-1:0] r_pv;
  logic [TS_W-1:0]   r_ps [NUM_CH];

  logic [PW-1:0]     r_rr;
  logic              w_grant_vld;
  logic [PW-1:0]     w_grant_idx;
  logic [NUM_CH-1:0] w_grant_oh;

  logic [DW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [AW:0]       r_level;
  logic              w_full, w_push, w_pop, w_tvalid;

  logic [15:0]       r_drop_cnt;
  logic [4:0]        w_ndrop;
  logic [16:0]       w_drop_sum;

  // The previous-value register is held at 1 until the synchroniser has
  // filled, so a line already high at reset release never looks like an edge.
  always_ff @(posedge sample_clk) begin
    if (!resetn) r_state <= ST_WARM0;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_armed     = 1'b0;
    unique case (r_state)
      ST_WARM0: w_state_nxt = ST_WARM1;
      ST_WARM1: w_state_nxt = ST_RUN;
      ST_RUN:   w_armed     = 1'b1;
      default:  w_state_nxt = ST_WARM0;
    endcase
  end

  // r_ts_d1 lags one cycle so the stamp loaded two edges after first sampling
  // equals the counter value produced by that sampling edge.
  always_ff @(posedge sample_clk) begin
    if (!resetn) begin
      r_ts_ctr <= '0;
      r_ts_d1  <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '1;
    end else begin
      r_ts_ctr <= r_ts_ctr + TS_W'(1);
      r_ts_d1  <= r_ts_ctr;
      r_sync1  <= pulse_i;
      r_sync2  <= r_sync1;
      r_prev   <= w_armed ? r_sync2 : '1;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;

  generate
    if (DEADTIME > 0) begin : g_dead
      logic [DTW-1:0] r_dt [NUM_CH];

      always_ff @(posedge sample_clk) begin
        if (!resetn) begin
          for (int unsigned c = 0; c < NUM_CH; c++) r_dt[c] <= '0;
        end else begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_accept[c])        r_dt[c] <= DTW'(DEADTIME);
            else if (r_dt[c] != '0) r_dt[c] <= r_dt[c] - 1'b1;
          end
        end
      end

      always_comb begin
        w_dead = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) w_dead[c] = (r_dt[c] != '0);
      end
    end else begin : g_nodead
      assign w_dead = '0;
    end
  endgenerate

  assign w_accept = w_rise & ch_enable & ~w_dead;
  // A slot being granted this cycle counts as free, so the load wins.
  assign w_drop   = w_accept & r_pv & ~w_grant_oh;

  always_ff @(posedge sample_clk) begin
    if (!resetn) begin
      r_pv <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) r_ps[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_accept[c] && !w_drop[c]) begin
          r_pv[c] <= 1'b1;
          r_ps[c] <= r_ts_d1;
        end else if (w_grant_oh[c]) begin
          r_pv[c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin : arb
    logic [PW:0] v_idx;
    v_idx       = '0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    if (!w_full) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        v_idx = {1'b0, r_rr} + (PW+1)'(i);
        if (v_idx >= (PW+1)'(NUM_CH)) v_idx = v_idx - (PW+1)'(NUM_CH);
        if (!w_grant_vld && r_pv[v_idx[PW-1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = v_idx[PW-1:0];
        end
      end
    end
    if (w_grant_vld) w_grant_oh[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge sample_clk) begin
    if (!resetn)          r_rr <= '0;
    else if (w_grant_vld) r_rr <= (w_grant_idx == PW'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;
  end

  assign w_full   = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_tvalid = (r_level != '0);
  assign w_push   = w_grant_vld;
  assign w_pop    = w_tvalid & m_axis.tready;

  always_ff @(posedge sample_clk) begin
    if (resetn && w_push) r_mem[r_wr] <= {ID_W'(w_grant_idx), r_ps[w_grant_idx]};
  end

  always_ff @(posedge sample_clk) begin
    if (!resetn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_ndrop = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) w_ndrop = w_ndrop + 5'(w_drop[c]);
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_ndrop);
  end

  always_ff @(posedge sample_clk) begin
    if (!resetn)            r_drop_cnt <= '0;
    else if (w_drop_sum[16]) r_drop_cnt <= '1;
    else                    r_drop_cnt <= w_drop_sum[15:0];
  end

  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tdata  = w_tvalid ? r_mem[r_rd] : '0;
  assign drop_cnt      = r_drop_cnt;
  assign fifo_level    = r_level;

endmodule

// File: tb/tb_multi_pulse_timestamper.sv
// Self-checking bench for multi_pulse_timestamper: directed scenarios on three
// parameterisations plus a randomized run against a per-channel event model.
module tb_multi_pulse_timestamper;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0]  pa = '0, ea = '0, pb = '0, eb = '0, pc = '0, ec = '0;
  logic [15:0] drop_a, drop_b, drop_c;
  logic [4:0]  lvl_a, lvl_b, lvl_c;

  multi_pulse_timestamper_if #(.DATA_W(32)) axa ();
  multi_pulse_timestamper_if #(.DATA_W(7))  axb ();
  multi_pulse_timestamper_if #(.DATA_W(32)) axc ();

  multi_pulse_timestamper #(.NUM_CH(8), .ID_W(3), .TS_W(29), .FIFO_DEPTH(16), .DEADTIME(0)) u_dut_a (
    .sample_clk(clk), .resetn(resetn), .pulse_i(pa), .ch_enable(ea),
    .m_axis(axa), .drop_cnt(drop_a), .fifo_level(lvl_a));

  multi_pulse_timestamper #(.NUM_CH(8), .ID_W(3), .TS_W(4), .FIFO_DEPTH(16), .DEADTIME(0)) u_dut_b (
    .sample_clk(clk), .resetn(resetn), .pulse_i(pb), .ch_enable(eb),
    .m_axis(axb), .drop_cnt(drop_b), .fifo_level(lvl_b));

  multi_pulse_timestamper #(.NUM_CH(8), .ID_W(3), .TS_W(29), .FIFO_DEPTH(16), .DEADTIME(8)) u_dut_c (
    .sample_clk(clk), .resetn(resetn), .pulse_i(pc), .ch_enable(ec),
    .m_axis(axc), .drop_cnt(drop_c), .fifo_level(lvl_c));

  always #5 clk = ~clk;

  // Edges with resetn high since reset: the value the stamp counter should hold.
  always @(posedge clk) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int exp_q [8][$];

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Returns at the negedge following edge n.
  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc: cyc=%0d required %0d", cyc, n);
    end
  endtask

  task automatic test_reset();
    axa.tready = 1'b1; axb.tready = 1'b1; axc.tready = 1'b1;
    do_reset();
    checks++; if (axa.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_a: got %b required 0", axa.tvalid); end
    checks++; if (axa.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata_a: got %h required 0", axa.tdata); end
    checks++; if (drop_a !== 16'h0) begin errors++; $display("FAIL reset_drop_a: got %h required 0", drop_a); end
    checks++; if (lvl_a !== 5'd0) begin errors++; $display("FAIL reset_level_a: got %0d required 0", lvl_a); end
    checks++; if (axb.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_b: got %b required 0", axb.tvalid); end
    checks++; if (axc.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_c: got %b required 0", axc.tvalid); end
  endtask

  task automatic test_single_event();
    ea = '1; axa.tready = 1'b1;
    do_reset();
    wait_cyc(9);  pa[2] = 1'b1;
    wait_cyc(12); pa = '0;
    checks++; if (axa.tvalid !== 1'b0) begin errors++; $display("FAIL single_early: tvalid=%b required 0", axa.tvalid); end
    wait_cyc(13);
    checks++; if (axa.tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid: got %b required 1", axa.tvalid); end
    checks++; if (axa.tdata !== {3'd2, 29'd10}) begin errors++; $display("FAIL single_tdata: got %h required %h", axa.tdata, {3'd2, 29'd10}); end
    wait_cyc(14);
    checks++; if (axa.tvalid !== 1'b0) begin errors++; $display("FAIL single_one_beat: tvalid=%b required 0", axa.tvalid); end
    checks++; if (drop_a !== 16'h0) begin errors++; $display("FAIL single_drop: got %0d required 0", drop_a); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp [3];
    exp[0] = {3'd0, 29'd20}; exp[1] = {3'd3, 29'd20}; exp[2] = {3'd7, 29'd20};
    ea = '1; axa.tready = 1'b1;
    do_reset();
    wait_cyc(19); pa = 8'h89;
    wait_cyc(21); pa = '0;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(23 + i);
      checks++;
      if (axa.tvalid !== 1'b1 || axa.tdata !== exp[i]) begin
        errors++;
        $display("FAIL simult_beat%0d: got v=%b d=%h required v=1 d=%h", i, axa.tvalid, axa.tdata, exp[i]);
      end
    end
    wait_cyc(26);
    checks++; if (axa.tvalid !== 1'b0) begin errors++; $display("FAIL simult_extra: tvalid=%b required 0", axa.tvalid); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [31:0] exp;
    ea = '1; axa.tready = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wait_cyc(9 + 4 * i);  pa[1] = 1'b1;
      wait_cyc(10 + 4 * i); pa[1] = 1'b0;
    end
    wait_cyc(92);
    checks++; if (lvl_a !== 5'd16) begin errors++; $display("FAIL bp_level: got %0d required 16", lvl_a); end
    checks++; if (drop_a !== 16'd3) begin errors++; $display("FAIL bp_drop: got %0d required 3", drop_a); end
    checks++; if (axa.tdata !== {3'd1, 29'd10}) begin errors++; $display("FAIL bp_hold: got %h required %h", axa.tdata, {3'd1, 29'd10}); end
    axa.tready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (axa.tvalid) begin
        exp = {3'd1, 29'(10 + 4 * n)};
        checks++;
        if (axa.tdata !== exp) begin errors++; $display("FAIL bp_drain%0d: got %h required %h", n, axa.tdata, exp); end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n != 17) begin errors++; $display("FAIL bp_count: got %0d beats required 17", n); end
    checks++; if (drop_a !== 16'd3) begin errors++; $display("FAIL bp_drop_final: got %0d required 3", drop_a); end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    ea = '1; axa.tready = 1'b0;
    do_reset();
    wait_cyc(9);  pa = 8'h1F;
    wait_cyc(10); pa = '0;
    wait_cyc(18);
    checks++; if (lvl_a !== 5'd5) begin errors++; $display("FAIL midrst_queued: got %0d required 5", lvl_a); end
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (axa.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b required 0", axa.tvalid); end
    checks++; if (lvl_a !== 5'd0) begin errors++; $display("FAIL midrst_level: got %0d required 0", lvl_a); end
    resetn = 1'b1; axa.tready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (axa.tvalid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale: got %0d beats required 0", seen); end
  endtask

  task automatic test_random();
    int lvl [8], left [8];
    logic held = 1'b0;
    logic [31:0] held_d = '0;
    logic tr;
    int ch;
    logic [28:0] exp;
    axa.tready = 1'b1;
    pa = '0;
    ea = 8'($urandom) | 8'h01;
    for (int c = 0; c < 8; c++) begin exp_q[c].delete(); lvl[c] = 0; left[c] = $urandom_range(5, 30); end
    do_reset();
    for (int t = 0; t < 3060; t++) begin
      tr = ($urandom_range(0, 3) != 0) || (t >= 3000);
      axa.tready = tr;
      if (axa.tvalid) begin
        if (held) begin
          checks++;
          if (axa.tdata !== held_d) begin errors++; $display("FAIL rand_stable: got %h required %h", axa.tdata, held_d); end
        end
        if (tr) begin
          held = 1'b0;
          ch = int'(axa.tdata[31:29]);
          checks++;
          if (exp_q[ch].size() == 0) begin
            errors++; $display("FAIL rand_unexpected: got %h required no beat on ch %0d", axa.tdata, ch);
          end else begin
            exp = 29'(exp_q[ch].pop_front());
            if (axa.tdata[28:0] !== exp) begin errors++; $display("FAIL rand_stamp ch%0d: got %0d required %0d", ch, axa.tdata[28:0], exp); end
          end
        end else begin
          held = 1'b1; held_d = axa.tdata;
        end
      end else begin
        held = 1'b0;
      end
      // Each low-to-high sample of an enabled line is one event stamped with that edge.
      for (int c = 0; c < 8; c++) begin
        if (t < 2980) begin
          left[c]--;
          if (left[c] <= 0) begin
            if (lvl[c] == 0) begin
              lvl[c] = 1; left[c] = $urandom_range(1, 4);
              if (ea[c]) exp_q[c].push_back(cyc + 1);
            end else begin
              lvl[c] = 0; left[c] = $urandom_range(24, 40);
            end
          end
        end else begin
          lvl[c] = 0;
        end
        pa[c] = (lvl[c] != 0);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin errors++; $display("FAIL rand_missing ch%0d: got %0d undelivered required 0", c, exp_q[c].size()); end
    end
    checks++; if (drop_a !== 16'h0) begin errors++; $display("FAIL rand_drop: got %0d required 0", drop_a); end
  endtask

  task automatic test_deadtime();
    logic [31:0] got [$];
    pc = 8'h20; ec = '1; axc.tready = 1'b1;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      if (axc.tvalid) got.push_back(axc.tdata);
      pc[4] = (cyc == 29 || cyc == 34 || cyc == 39);
      @(negedge clk);
    end
    pc = '0;
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL dead_count: got %0d beats required 2", got.size());
    end else begin
      checks++; if (got[0] !== {3'd4, 29'd30}) begin errors++; $display("FAIL dead_first: got %h required %h", got[0], {3'd4, 29'd30}); end
      checks++; if (got[1] !== {3'd4, 29'd40}) begin errors++; $display("FAIL dead_second: got %h required %h", got[1], {3'd4, 29'd40}); end
    end
  endtask

  task automatic test_wrap();
    logic [6:0] got [$];
    pb = '0; eb = '1; axb.tready = 1'b1;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      if (axb.tvalid) got.push_back(axb.tdata);
      pb[0] = (cyc == 14 || cyc == 16);
      @(negedge clk);
    end
    pb = '0;
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL wrap_count: got %0d beats required 2", got.size());
    end else begin
      checks++; if (got[0] !== {3'd0, 4'd15}) begin errors++; $display("FAIL wrap_first: got %h required %h", got[0], {3'd0, 4'd15}); end
      checks++; if (got[1] !== {3'd0, 4'd1}) begin errors++; $display("FAIL wrap_second: got %h required %h", got[1], {3'd0, 4'd1}); end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_simultaneous();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_deadtime();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_pulse_timestamper.md
# multi_pulse_timestamper

Parametrised multi-channel successor to the single-line pulse timestamper. It takes NUM_CH asynchronous pulse lines and synchronises each one into sample_clk. Each rising edge is stamped with a free-running counter value, and stamps are merged through a round-robin arbiter into an internal FIFO. The FIFO output is an AXI-Stream master that feeds the timestamp DMA path; all logic runs in a single clock domain.

## Interface
- NUM_CH, 8: number of pulse lines, 1..16.
- ID_W, 3: channel-ID field width; must satisfy 2^ID_W >= NUM_CH.
- TS_W, 29: timestamp field width.
- FIFO_DEPTH, 16: FIFO entries; must be a power of 2, minimum 2.
- DEADTIME, 0: cycles after a detection during which further edges on that channel are ignored; 0 disables.

Ports (name, direction, width, meaning):
- sample_clk, in, 1: sole clock.
- resetn, in, 1: synchronous, active-low reset.
- pulse_i, in, NUM_CH: asynchronous pulse lines.
- ch_enable, in, NUM_CH: per-channel detect enable.
- m_axis_tdata, out, ID_W+TS_W: {channel id, stamp}.
- m_axis_tvalid, out, 1: FIFO not empty.
- m_axis_tready, in, 1: downstream accept.
- drop_cnt, out, 16: saturating count of lost events.
- fifo_level, out, log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Counter.** ts_ctr (TS_W bits) equals the number of sample_clk edges with resetn high since reset, mod 2^TS_W.
  - Wrap from all-ones to 0 is silent.
  - Stamps are raw counter values; no wrap flag is produced.
- **Synchroniser and edge detect.** Each line passes through a 2-flop synchroniser, then a rising-edge detector.
  - The previous-value register resets to 1, so a line already high at reset release produces no event.
- **Stamp definition.** Stamp = the ts_ctr value produced by the same edge that first samples pulse_i high. The implementation must delay the counter to compensate for synchroniser latency.
- **Event acceptance.** A detected edge on channel c is accepted only if ch_enable[c]=1 and c is not in deadtime.
  - Deadtime lasts DEADTIME cycles after the acceptance edge, whether or not the event is later dropped.
- **Pending register.** Each channel has one pending slot (stamp + valid).
  - Accepted event with the slot empty: slot is loaded.
  - Accepted event with the slot full: the new event is discarded and drop_cnt increments.
  - Same-cycle clear and load of a slot: the load wins, with no drop.
- **Arbiter.** Each cycle, if fifo_level < FIFO_DEPTH, it grants the first valid pending slot searching from rr_ptr upward, with wrap.
  - The granted slot is written to the FIFO and cleared.
  - rr_ptr then becomes grant+1 mod NUM_CH.
  - rr_ptr resets to 0.
- **FIFO.** First-word-fall-through.
  - Pop occurs on tvalid & tready.
  - Push is refused when full, even if a pop happens in the same cycle; the pending slot simply holds.
  - Push and pop in the same cycle leave the level unchanged.
- **drop_cnt.** Saturates at 0xFFFF.
  - When several channels drop in the same cycle, it increments by the number of drops, saturating.
- **ch_enable deassert.** Deasserting ch_enable blocks new events only; an existing pending slot still drains.

## Timing
- **Reset values.** When resetn=0 at an edge, the following reset to 0: m_axis_tvalid, m_axis_tdata, drop_cnt, fifo_level, ts_ctr, pending slots, deadtime counters and synchroniser flops.
  - Reset mid-operation discards all FIFO content and pending events.
- **Latency, uncontended.** For pulse_i first sampled high at edge k:
  - edge k+1: second sync stage.
  - edge k+2: pending slot loaded.
  - edge k+3: FIFO written; m_axis_tvalid high from k+3.
- **Minimum pulse width.** 1 sample_clk period.
  - Narrower pulses may be missed.
  - A pulse low for ≥1 period between highs yields two edges.
- **Throughput.** One FIFO write per cycle across all channels, and one read per cycle.
- **Output stability.** m_axis_tdata is stable while tvalid=1 and tready=0.

## Test plan
- **Single event.** Release reset, then raise pulse_i[2] at edge 10 and hold 3 cycles with tready=1 → one beat {2, 10}, tvalid high from edge 13, drop_cnt=0.
- **Simultaneous edges.** Raise pulse_i[0], [3] and [7] at edge 20 → beats {0,20}, {3,20}, {7,20} in that order on consecutive cycles, with rr_ptr=0 at that point.
- **Backpressure.** Hold tready=0 and send 20 single-cycle pulses on ch 1 every 4 cycles → fifo_level=16 with the 17th event held pending, later events dropped, and drop_cnt=3. Releasing tready drains 17 beats in order.
- **Reset-time high and deadtime.** Hold pulse_i[5] high through reset release → no event. With DEADTIME=8, pulse ch 4 at edges 30 and 35 → only {4,30}. A further pulse at 40 → {4,40}.
- **Counter wrap.** Use TS_W=4 and pulse ch 0 at edges 15 and 17 → stamps 15 then 1.
- **Mid-operation reset.** Assert resetn=0 for 1 cycle with 5 entries queued → tvalid=0 and fifo_level=0 on the next cycle, and no stale beats afterwards.
